// File: rtl/pkt_commit_buffer.sv
// Store-and-forward packet buffer: bytes are stored speculatively and committed or rewound on the CRC verdict.
// Build option PKT_STRIP_CRC_EN removes the trailing CRC byte from every committed packet.
module pkt_commit_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int LEN_DEPTH   = 16,
    parameter int MAX_PKT_LEN = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_sop,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_eop,
    input  logic                       crc_valid,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_sop,
    output logic                       rd_eop,
    output logic [$clog2(LEN_DEPTH):0] pkt_cnt,
    output logic                       drop_pulse
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int LW    = $clog2(MAX_PKT_LEN) + 1;
    localparam int LA    = $clog2(LEN_DEPTH);
    localparam int CW    = LA + 1;
`ifdef PKT_STRIP_CRC_EN
    localparam int STRIP = 1;
`else
    localparam int STRIP = 0;
`endif
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [CW-1:0] LF_FULL  = CW'(LEN_DEPTH);
    localparam logic [PW-1:0] STRIP_P  = PW'(STRIP);
    localparam logic [LW-1:0] STRIP_L  = LW'(STRIP);
    localparam logic [LW-1:0] MIN_L    = LW'(STRIP + 1);
    localparam logic [LW-1:0] MAX_L    = LW'(MAX_PKT_LEN);

    // IDLE: wait sop | RECV: store bytes | WAIT: crc verdict | DISCARD: drop until eop
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_DISCARD} state_t;

    state_t                state_q;
    logic [PW-1:0]         wr_ptr_q, cm_ptr_q, rd_ptr_q, rf_ptr_q;
    logic [LW-1:0]         len_q, pos_q;
    logic [CW-1:0]         lf_wr_q, lf_rd_q, lf_fe_q;
    logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic                  drop_q;
    logic                  rd_valid_q, rd_sop_q, rd_eop_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [LW-1:0]         lf_mem_q [LEN_DEPTH];

    logic [PW-1:0] used, commit_ptr_d;
    logic [LW-1:0] head_len;
    logic          full, lf_full, wr_en, commit, wait_fail;
    logic          fetch_avail, load, xfer, pop, last_byte;

    assign used         = wr_ptr_q - rd_ptr_q;
    assign full         = (used == FULL_LVL);
    assign lf_full      = ((lf_wr_q - lf_rd_q) == LF_FULL);
    assign wr_en        = (state_q == S_RECV) && !wr_sop && !wr_eop && wr_valid
                          && !full && (len_q < MAX_L);
    assign commit       = (state_q == S_WAIT) && crc_valid && (len_q >= MIN_L);
    assign wait_fail    = (state_q == S_WAIT) && !commit;
    assign commit_ptr_d = wr_ptr_q - STRIP_P;

    assign head_len    = lf_mem_q[lf_fe_q[LA-1:0]];
    assign last_byte   = (pos_q == head_len - 1'b1);
    assign fetch_avail = (lf_fe_q != lf_wr_q);
    assign xfer        = rd_valid_q && rd_ready;
    assign load        = fetch_avail && (!rd_valid_q || rd_ready);
    assign pop         = xfer && rd_eop_q;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (commit && !pop)
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        else if (!commit && pop)
            pkt_cnt_d = pkt_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            ram_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        if (commit)
            lf_mem_q[lf_wr_q[LA-1:0]] <= len_q - STRIP_L;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            len_q     <= '0;
            lf_wr_q   <= '0;
            pkt_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q    <= 1'b0;
            pkt_cnt_q <= pkt_cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                len_q    <= len_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (wr_sop) begin
                        len_q   <= '0;
                        state_q <= lf_full ? S_DISCARD : S_RECV;
                    end
                end
                S_RECV: begin
                    if (wr_sop) begin
                        wr_ptr_q <= cm_ptr_q;
                        len_q    <= '0;
                        drop_q   <= 1'b1;
                    end else if (wr_eop) begin
                        state_q <= S_WAIT;
                    end else if (wr_valid && !wr_en) begin
                        state_q <= S_DISCARD;
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        wr_ptr_q <= commit_ptr_d;
                        cm_ptr_q <= commit_ptr_d;
                        lf_wr_q  <= lf_wr_q + 1'b1;
                    end else begin
                        wr_ptr_q <= cm_ptr_q;
                    end
                    state_q <= S_IDLE;
                end
                S_DISCARD: begin
                    if (wr_eop) begin
                        wr_ptr_q <= cm_ptr_q;
                        drop_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Fetch runs ahead of the pop pointer so the next packet can load while the previous eop waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rf_ptr_q   <= '0;
            pos_q      <= '0;
            lf_rd_q    <= '0;
            lf_fe_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sop_q   <= 1'b0;
            rd_eop_q   <= 1'b0;
        end else begin
            if (xfer)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop)
                lf_rd_q <= lf_rd_q + 1'b1;
            if (load) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= ram_q[rf_ptr_q[ADDR_WIDTH-1:0]];
                rd_sop_q   <= (pos_q == '0);
                rd_eop_q   <= last_byte;
                rf_ptr_q   <= rf_ptr_q + 1'b1;
                if (last_byte) begin
                    pos_q   <= '0;
                    lf_fe_q <= lf_fe_q + 1'b1;
                end else begin
                    pos_q <= pos_q + 1'b1;
                end
            end else if (xfer) begin
                rd_valid_q <= 1'b0;
                rd_sop_q   <= 1'b0;
                rd_eop_q   <= 1'b0;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_sop     = rd_sop_q;
    assign rd_eop     = rd_eop_q;
    assign pkt_cnt    = pkt_cnt_q;
    // A CRC failure is reported during the verdict cycle itself; aborts/discards one cycle after the pulse.
    assign drop_pulse = drop_q | wait_fail;

endmodule

// File: tb/tb_pkt_commit_buffer.sv
// Directed bench for pkt_commit_buffer: cycle vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pkt_commit_buffer;
`ifdef PKT_STRIP_CRC_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_sop = 1'b0, wr_valid = 1'b0, wr_eop = 1'b0, crc_valid = 1'b0, rd_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid, rd_sop, rd_eop, drop_pulse;
    logic [7:0] rd_data;
    logic [4:0] pkt_cnt;

    always #5 clk = ~clk;

    pkt_commit_buffer dut (
        .clk(clk), .rst(rst),
        .wr_sop(wr_sop), .wr_valid(wr_valid), .wr_data(wr_data), .wr_eop(wr_eop),
        .crc_valid(crc_valid), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .pkt_cnt(pkt_cnt), .drop_pulse(drop_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_d[$];
    bit         exp_s[$];
    bit         exp_e[$];

    typedef struct {
        logic sop, vld, eop, crc;
        logic [7:0] d;
        logic ev;
        logic [7:0] ed;
        logic es, ee;
        logic [4:0] ec;
        logic edrop;
    } vec_t;
    vec_t tbl[31];

    function automatic vec_t mk(input logic sop, input logic vld, input logic [7:0] d,
                                input logic eop, input logic crc, input logic ev,
                                input logic [7:0] ed, input logic es, input logic ee,
                                input logic [4:0] ec, input logic edrop);
        vec_t v;
        v.sop = sop; v.vld = vld; v.d = d; v.eop = eop; v.crc = crc;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.ec = ec; v.edrop = edrop;
        return v;
    endfunction

    function automatic logic [16:0] obs();
        return {rd_valid, rd_valid ? rd_data : 8'h00, rd_valid & rd_sop, rd_valid & rd_eop,
                pkt_cnt, drop_pulse};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bit crc, output bit drop_seen);
        wr_sop = 1'b1; cyc(); wr_sop = 1'b0;
        foreach (tx_q[i]) begin
            wr_valid = 1'b1; wr_data = tx_q[i]; cyc();
        end
        wr_valid = 1'b0;
        wr_eop = 1'b1; cyc(); wr_eop = 1'b0;
        crc_valid = crc;
        @(negedge clk);
        drop_seen = drop_pulse;
        cyc();
        crc_valid = 1'b0;
    endtask

    task automatic expect_pkt();
        int n;
        n = tx_q.size() - int'(STRIP);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(tx_q[i]);
            exp_s.push_back(i == 0);
            exp_e.push_back(i == n - 1);
        end
    endtask

    task automatic read_expect(input string name, input int budget);
        int got = 0;
        int cycles = 0;
        rd_ready = 1'b1;
        while (got < exp_d.size() && cycles < budget) begin
            @(negedge clk);
            if (rd_valid) begin
                chk($sformatf("%s_byte%0d", name, got), {rd_data, rd_sop, rd_eop},
                    {exp_d[got], exp_s[got], exp_e[got]});
                got++;
            end
            cyc();
            cycles++;
        end
        rd_ready = 1'b0;
        if (got < exp_d.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, got, exp_d.size());
        end
        exp_d.delete(); exp_s.delete(); exp_e.delete();
        @(negedge clk);
        chk({name, "_empty"}, {rd_valid, pkt_cnt}, 6'd0);
        cyc();
    endtask

    initial begin
        bit dr;

        // Good packet, then CRC-fail packet followed by a good packet, rd_ready held high.
        tbl[0]  = mk(1,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[1]  = mk(0,1,8'h11,0,0, 0,8'h00,0,0,0,0);
        tbl[2]  = mk(0,1,8'h22,0,0, 0,8'h00,0,0,0,0);
        tbl[3]  = mk(0,1,8'h33,0,0, 0,8'h00,0,0,0,0);
        tbl[4]  = mk(0,1,8'hC4,0,0, 0,8'h00,0,0,0,0);
        tbl[5]  = mk(0,0,8'h00,1,0, 0,8'h00,0,0,0,0);
        tbl[6]  = mk(0,0,8'h00,0,1, 0,8'h00,0,0,0,0);
        tbl[7]  = mk(0,0,8'h00,0,0, 0,8'h00,0,0,1,0);
        tbl[8]  = mk(0,0,8'h00,0,0, 1,8'h11,1,0,1,0);
        tbl[9]  = mk(0,0,8'h00,0,0, 1,8'h22,0,0,1,0);
        tbl[10] = mk(0,0,8'h00,0,0, 1,8'h33,0,STRIP,1,0);
        tbl[11] = mk(0,0,8'h00,0,0, !STRIP,STRIP ? 8'h00 : 8'hC4,0,!STRIP,STRIP ? 5'd0 : 5'd1,0);
        tbl[12] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[13] = mk(1,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[14] = mk(0,1,8'h11,0,0, 0,8'h00,0,0,0,0);
        tbl[15] = mk(0,1,8'h22,0,0, 0,8'h00,0,0,0,0);
        tbl[16] = mk(0,1,8'h33,0,0, 0,8'h00,0,0,0,0);
        tbl[17] = mk(0,1,8'hC4,0,0, 0,8'h00,0,0,0,0);
        tbl[18] = mk(0,0,8'h00,1,0, 0,8'h00,0,0,0,0);
        tbl[19] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,1);
        tbl[20] = mk(1,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[21] = mk(0,1,8'hA0,0,0, 0,8'h00,0,0,0,0);
        tbl[22] = mk(0,1,8'hA1,0,0, 0,8'h00,0,0,0,0);
        tbl[23] = mk(0,1,8'h5E,0,0, 0,8'h00,0,0,0,0);
        tbl[24] = mk(0,0,8'h00,1,0, 0,8'h00,0,0,0,0);
        tbl[25] = mk(0,0,8'h00,0,1, 0,8'h00,0,0,0,0);
        tbl[26] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,1,0);
        tbl[27] = mk(0,0,8'h00,0,0, 1,8'hA0,1,0,1,0);
        tbl[28] = mk(0,0,8'h00,0,0, 1,8'hA1,0,STRIP,1,0);
        tbl[29] = mk(0,0,8'h00,0,0, !STRIP,STRIP ? 8'h00 : 8'h5E,0,!STRIP,STRIP ? 5'd0 : 5'd1,0);
        tbl[30] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);

        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", obs(), 17'd0);
        cyc();

        rd_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            wr_sop = tbl[i].sop; wr_valid = tbl[i].vld; wr_data = tbl[i].d;
            wr_eop = tbl[i].eop; crc_valid = tbl[i].crc;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(),
                {tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ee, tbl[i].ec, tbl[i].edrop});
            cyc();
        end
        wr_sop = 1'b0; wr_valid = 1'b0; wr_eop = 1'b0; crc_valid = 1'b0; rd_ready = 1'b0;

        // Oversize packet is dropped; a short packet after it still passes.
        tx_q.delete();
        for (int i = 0; i < 129; i++) tx_q.push_back(8'(i + 1));
        send_pkt(1'b1, dr);
        chk("oversize_drop", dr, 1'b1);
        @(negedge clk);
        chk("oversize_cnt", pkt_cnt, 5'd0);
        cyc();
        tx_q = '{8'h01, 8'h02, 8'h03};
        send_pkt(1'b1, dr);
        chk("short_nodrop", dr, 1'b0);
        expect_pkt();
        read_expect("short", 40);

        // Length FIFO fills at 16 packets; the 17th is discarded.
        for (int k = 0; k < 17; k++) begin
            tx_q.delete();
            for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'h40 + 4 * k + i));
            send_pkt(1'b1, dr);
            if (k < 16) expect_pkt();
            chk($sformatf("fill_drop%0d", k), dr, k == 16);
        end
        repeat (3) cyc();
        @(negedge clk);
        chk("fill_cnt", pkt_cnt, 5'd16);
        chk("fill_hold", {rd_valid, rd_data, rd_sop, rd_eop}, {1'b1, 8'h40, 1'b1, 1'b0});
        cyc();
        read_expect("fill", 200);

        // Second sop after two bytes aborts the first packet.
        wr_sop = 1'b1; cyc(); wr_sop = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hEE; cyc();
        wr_data = 8'hEF; cyc();
        wr_valid = 1'b0; wr_sop = 1'b1; cyc(); wr_sop = 1'b0;
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        wr_valid = 1'b1; wr_data = 8'h31;
        @(negedge clk);
        chk("abort_drop", drop_pulse, 1'b1);
        cyc();
        for (int i = 1; i < 4; i++) begin
            wr_data = tx_q[i]; cyc();
        end
        wr_valid = 1'b0; wr_eop = 1'b1; cyc(); wr_eop = 1'b0;
        crc_valid = 1'b1;
        @(negedge clk);
        chk("abort_commit_nodrop", drop_pulse, 1'b0);
        cyc();
        crc_valid = 1'b0;
        @(negedge clk);
        chk("abort_cnt", pkt_cnt, 5'd1);
        cyc();
        expect_pkt();
        read_expect("abort", 40);

        // Reset mid-packet with two committed packets waiting.
        tx_q = '{8'h51, 8'h52};
        send_pkt(1'b1, dr);
        tx_q = '{8'h61, 8'h62, 8'h63};
        send_pkt(1'b1, dr);
        repeat (3) cyc();
        @(negedge clk);
        chk("pre_reset_cnt", {rd_valid, pkt_cnt}, {1'b1, 5'd2});
        cyc();
        wr_sop = 1'b1; cyc(); wr_sop = 1'b0;
        wr_valid = 1'b1; wr_data = 8'h71; cyc();
        wr_data = 8'h72; cyc();
        wr_valid = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;
        @(negedge clk);
        chk("midpkt_reset", obs(), 17'd0);
        cyc();
        tx_q = '{8'h7A, 8'h7B, 8'h7C};
        send_pkt(1'b1, dr);
        expect_pkt();
        read_expect("post_reset", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
